sar_scan_scheduler: RTL and testbench
=====================================

# sar_scan_scheduler

Multi-channel conversion scheduler for the 5-bit successive-approximation ADC datapath. It latches a channel-enable mask, selects each enabled analog channel in ascending round-robin order, drives the sample/hold control, and runs one MSB-first bit trial per cycle against the comparator. Each finished code is presented on a valid/ready result port. The block sits between the analog front-end (mux, S/H, capacitive DAC, comparator) and the digital consumer that reads conversion results.

## Interface
- `NCH`, 4: number of analog input channels (2..8)
- `NBITS`, 5: conversion resolution in bits
- `SAMPLE_CYCLES`, 2: cycles the S/H switch is held closed per conversion (≥1)
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin one scan; honoured only in IDLE
- `cont`  in  1  continuous mode: restart the scan automatically after the last channel
- `ch_mask`  in  NCH  channel enables; latched at scan start
- `comp`  in  1  comparator output; 1 = keep current trial bit
- `ch_sel`  out  clog2(NCH)  analog mux select
- `sample`  out  1  S/H switch control
- `dac`  out  NBITS  DAC code under test
- `busy`  out  1  high in every state except IDLE
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  NBITS  conversion code
- `res_ch`  out  clog2(NCH)  channel of `res_data`
- `scan_done`  out  1  one-cycle pulse after the last enabled channel's result is accepted into the output register

## Operation
- States: IDLE, SAMPLE, CONVERT, HOLD.
- IDLE: if `start && ch_mask != 0`:
  - latch the mask;
  - set `ch_sel` to the lowest enabled channel;
  - go to SAMPLE.
- `start` with a zero mask is ignored. `start` outside IDLE is ignored.
- SAMPLE:
  - `sample` = 1 and `dac` = 0 for exactly SAMPLE_CYCLES cycles.
  - Then go to CONVERT with trial index k = NBITS-1.
- CONVERT, one cycle per bit, MSB first:
  - `dac` = decided upper bits | (1<<k), with lower bits 0.
  - At the clock edge, bit k takes the value of `comp`, then k decrements.
  - After the k = 0 trial, the full code is complete.
- Completion, when the output register is free (`!res_valid`, or `res_valid && res_ready` in the same cycle):
  - load `res_data`/`res_ch`;
  - assert `res_valid`.
- Next channel after completion:
  - advance to the next higher enabled channel in the latched mask and go to SAMPLE;
  - if none remain, pulse `scan_done`; then go to SAMPLE at the lowest enabled channel if `cont`=1 (mask re-latched from `ch_mask`), otherwise go to IDLE.
  - If the re-latched mask is 0, go to IDLE.
- Completion when the output register is occupied:
  - enter HOLD and keep the finished code internally; `sample` = 0, `dac` holds the final code.
  - Leave HOLD on the cycle `res_ready` is seen, with the same transfer as above.
  - No result is ever dropped or overwritten.
- Result handshake:
  - `res_valid` stays high until `res_valid && res_ready`.
  - `res_data`/`res_ch` are stable while valid.
- Widths: trial and code registers are NBITS wide. Channel index wraps modulo NCH. No arithmetic overflow paths.

## Timing
- Reset values: IDLE; `ch_sel`, `sample`, `dac`, `busy`, `res_valid`, `res_data`, `res_ch` and `scan_done` are all 0. The internal code register is cleared.
- Reset mid-conversion or in HOLD: abort at the next edge; the pending result is discarded.
- `start` sampled at edge 0:
  - `busy`=`sample`=1 from cycle 1;
  - `sample` high for cycles 1..SAMPLE_CYCLES;
  - trials run in cycles SAMPLE_CYCLES+1..SAMPLE_CYCLES+NBITS;
  - `res_valid` rises at cycle SAMPLE_CYCLES+NBITS+1.
  - Defaults: valid at cycle 8.
- Per-channel period without backpressure: SAMPLE_CYCLES+NBITS cycles (7 with defaults). The next SAMPLE starts the cycle `res_valid` rises.
- `comp` is sampled only in CONVERT and is don't-care elsewhere.
- `ch_sel` changes only on the edge entering SAMPLE and is stable through SAMPLE, CONVERT and HOLD.
- `scan_done` is high in the same cycle the last channel's `res_valid` rises.

## Structure
- Package `sar_sched_pkg`:
  - state enum (IDLE, SAMPLE, CONVERT, HOLD);
  - default parameter constants;
  - a `next_channel(mask, cur)` function returning the next enabled index, with a found flag.
- Sub-module `sar_bit_engine`:
  - holds the trial index and code register;
  - inputs: `load`, `step`, `comp`;
  - outputs: `dac`, `code`, `last`.
- The top level owns the FSM, mask/channel logic, output register and handshake.

## Test plan
- Single scan, mask=4'b0101, `comp` pattern producing 5'b10110 on ch0 and 5'b01001 on ch2, `res_ready`=1:
  - results (ch0, 0x16) at cycle 8 and (ch2, 0x09) at cycle 15;
  - `scan_done` at cycle 15;
  - IDLE at cycle 16.
- Trial sequence on ch0 with `comp`=1,0,1,1,0: `dac` = 10000, 11000, 10100, 10110, 10111; result 10110.
- Backpressure, mask=4'b0011, `res_ready`=0 until cycle 20:
  - ch1 completes at cycle 15 and enters HOLD;
  - ch0 result is stable through cycle 20;
  - ch1 is valid from cycle 21; no loss.
- Ignored starts: `start` with mask=0 keeps `busy`=0; `start` during CONVERT changes nothing.
- Continuous mode, mask=4'b1000, `cont`=1: ch3 is converted every 7 cycles and `scan_done` pulses each result. Deasserting `cont` → IDLE after the current result.
- Reset asserted in cycle 4 (CONVERT) → all outputs 0 at cycle 5; a fresh `start` gives valid at the normal latency.

Source files
------------

// File: rtl/sar_sched_pkg.sv
// rtl/sar_sched_pkg.sv - shared types, defaults and channel-pick helpers for the SAR scan scheduler
package sar_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_HOLD
    } state_t;

    localparam int DEF_NCH           = 4;
    localparam int DEF_NBITS         = 5;
    localparam int DEF_SAMPLE_CYCLES = 2;
    localparam int MAX_NCH           = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } ch_pick_t;

    // Lowest enabled channel strictly above cur; found=0 when the scan is exhausted.
    function automatic ch_pick_t next_channel(input logic [MAX_NCH-1:0] mask, input logic [2:0] cur);
        ch_pick_t r;
        r = '0;
        for (int i = MAX_NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic ch_pick_t first_channel(input logic [MAX_NCH-1:0] mask);
        ch_pick_t r;
        r = '0;
        for (int i = MAX_NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// rtl/sar_bit_engine.sv - MSB-first successive-approximation trial/code register
module sar_bit_engine #(
    parameter int NBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             comp,
    output logic [NBITS-1:0] dac,
    output logic [NBITS-1:0] code,
    output logic             last
);
    localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [KW-1:0]    k;
    logic [NBITS-1:0] code_q;

    // code_q carries the decided upper bits plus the bit currently on trial.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= '0;
            k      <= '0;
        end else if (load) begin
            code_q <= NBITS'(1) << (NBITS - 1);
            k      <= KW'(NBITS - 1);
        end else if (step) begin
            code_q[k] <= comp;
            if (k != '0) begin
                code_q[k - 1'b1] <= 1'b1;
                k                <= k - 1'b1;
            end
        end
    end

    assign dac  = code_q;
    assign code = code_q;
    assign last = (k == '0);

endmodule

// File: rtl/sar_scan_scheduler.sv
// rtl/sar_scan_scheduler.sv - round-robin multi-channel SAR conversion scheduler with valid/ready results
module sar_scan_scheduler
    import sar_sched_pkg::*;
#(
    parameter int NCH           = DEF_NCH,
    parameter int NBITS         = DEF_NBITS,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   cont,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   comp,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic                   sample,
    output logic [NBITS-1:0]       dac,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NBITS-1:0]       res_data,
    output logic [$clog2(NCH)-1:0] res_ch,
    output logic                   scan_done
);
    localparam int CW  = $clog2(NCH);
    localparam int SCW = $clog2(SAMPLE_CYCLES + 1);

    state_t             state;
    logic [NCH-1:0]     mask_q;
    logic [SCW-1:0]     scnt;
    logic [NBITS-1:0]   eng_dac;
    logic [NBITS-1:0]   eng_code;
    logic               eng_last;
    logic               eng_load;
    logic               eng_step;
    logic               out_free;
    logic               finish;
    logic [NBITS-1:0]   fin_code;
    logic [MAX_NCH-1:0] mask_ext;
    logic [MAX_NCH-1:0] new_ext;
    ch_pick_t           nxt;
    ch_pick_t           first_new;

    always_comb begin
        mask_ext          = '0;
        mask_ext[NCH-1:0] = mask_q;
        new_ext           = '0;
        new_ext[NCH-1:0]  = ch_mask;
    end

    assign nxt       = next_channel(mask_ext, 3'(ch_sel));
    assign first_new = first_channel(new_ext);

    assign eng_load = (state == ST_SAMPLE) && (scnt == SCW'(SAMPLE_CYCLES - 1));
    assign eng_step = (state == ST_CONVERT);
    assign out_free = !res_valid || res_ready;
    assign finish   = ((state == ST_CONVERT) && eng_last && out_free) ||
                      ((state == ST_HOLD) && res_ready);

    // The last trial bit is not yet in the engine register when completing straight from CONVERT.
    always_comb begin
        fin_code = eng_code;
        if (state == ST_CONVERT) fin_code[0] = comp;
    end

    sar_bit_engine #(.NBITS(NBITS)) u_engine (
        .clk   (clk),
        .reset (reset),
        .load  (eng_load),
        .step  (eng_step),
        .comp  (comp),
        .dac   (eng_dac),
        .code  (eng_code),
        .last  (eng_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            ch_sel    <= '0;
            scnt      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ch    <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (res_valid && res_ready) res_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        mask_q <= ch_mask;
                        ch_sel <= CW'(first_new.idx);
                        scnt   <= '0;
                        state  <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (eng_load) state <= ST_CONVERT;
                    else          scnt  <= scnt + 1'b1;
                end
                ST_CONVERT: begin
                    if (eng_last && !out_free) state <= ST_HOLD;
                end
                ST_HOLD: ;
                default: state <= ST_IDLE;
            endcase

            // Shared transfer into the output register and hop to the next channel.
            if (finish) begin
                res_valid <= 1'b1;
                res_data  <= fin_code;
                res_ch    <= ch_sel;
                scnt      <= '0;
                if (nxt.found) begin
                    ch_sel <= CW'(nxt.idx);
                    state  <= ST_SAMPLE;
                end else begin
                    scan_done <= 1'b1;
                    if (cont && (ch_mask != '0)) begin
                        mask_q <= ch_mask;
                        ch_sel <= CW'(first_new.idx);
                        state  <= ST_SAMPLE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign busy   = (state != ST_IDLE);
    assign sample = (state == ST_SAMPLE);
    assign dac    = ((state == ST_CONVERT) || (state == ST_HOLD)) ? eng_dac : '0;

endmodule

// File: tb/tb_sar_scan_scheduler.sv
// tb/tb_sar_scan_scheduler.sv - directed self-checking bench for sar_scan_scheduler
module tb_sar_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cont;
    logic [3:0] ch_mask;
    logic       comp;
    logic [1:0] ch_sel;
    logic       sample;
    logic [4:0] dac;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [1:0] res_ch;
    logic       scan_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [4:0] pat0;
    logic [4:0] pat2;
    logic [4:0] dac_exp [5];

    sar_scan_scheduler #(.NCH(4), .NBITS(5), .SAMPLE_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .comp      (comp),
        .ch_sel    (ch_sel),
        .sample    (sample),
        .dac       (dac),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ch    (res_ch),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Start edge becomes edge 0; on return we sit in cycle 1.
    task automatic kick(input logic [3:0] m);
        ch_mask = m;
        start   = 1'b1;
        cyc     = 0;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cont = 1'b0; ch_mask = '0; comp = 1'b0; res_ready = 1'b1;
        pat0 = 5'b10110;
        pat2 = 5'b01001;
        dac_exp[0] = 5'b10000; dac_exp[1] = 5'b11000; dac_exp[2] = 5'b10100;
        dac_exp[3] = 5'b10110; dac_exp[4] = 5'b10111;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_outs", {ch_sel, sample, dac, res_valid, res_data, res_ch, scan_done}, 0);

        // Zero-mask start is ignored.
        ch_mask = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        check("zmask_busy", busy, 0);
        tick();
        check("zmask_busy2", busy, 0);

        // Single scan, mask 0101, plus an ignored start during CONVERT.
        kick(4'b0101);
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) begin
                check("s1_busy", busy, 1);
                check("s1_sample", sample, 1);
                check("s1_ch_sel", ch_sel, 0);
                check("s1_dac", dac, 0);
            end
            if (c == 2) check("s1_sample2", sample, 1);
            if (c >= 3 && c <= 7) begin
                check("s1_trial_dac", dac, dac_exp[c-3]);
                check("s1_trial_sample", sample, 0);
            end
            if (c == 7) check("s1_valid_early", res_valid, 0);
            if (c == 8) begin
                check("s1_res0", {res_valid, res_ch, res_data}, {1'b1, 2'd0, 5'h16});
                check("s1_done0", scan_done, 0);
                check("s1_next_ch", ch_sel, 2);
                check("s1_next_sample", sample, 1);
            end
            if (c == 15) begin
                check("s1_res2", {res_valid, res_ch, res_data}, {1'b1, 2'd2, 5'h09});
                check("s1_done", scan_done, 1);
            end
            if (c == 16) begin
                check("s1_idle", busy, 0);
                check("s1_done_pulse", scan_done, 0);
                check("s1_valid_drop", res_valid, 0);
            end
            comp = 1'b0;
            if (c >= 3 && c <= 7)   comp = pat0[7-c];
            if (c >= 10 && c <= 14) comp = pat2[14-c];
            start = (c == 4);
            if (c == 4) ch_mask = 4'b1111;
            if (c < 16) tick();
        end
        start = 1'b0;

        // Backpressure, mask 0011, consumer stalls until cycle 20.
        res_ready = 1'b0;
        kick(4'b0011);
        for (int c = 1; c <= 22; c++) begin
            if (c >= 8 && c <= 20)
                check("bp_hold_res0", {res_valid, res_ch, res_data}, {1'b1, 2'd0, 5'h15});
            if (c == 15) begin
                check("bp_hold_dac", dac, 5'h0A);
                check("bp_hold_sample", sample, 0);
                check("bp_hold_busy", busy, 1);
                check("bp_hold_ch_sel", ch_sel, 1);
            end
            if (c == 21) begin
                check("bp_res1", {res_valid, res_ch, res_data}, {1'b1, 2'd1, 5'h0A});
                check("bp_done", scan_done, 1);
            end
            if (c == 22) begin
                check("bp_valid_drop", res_valid, 0);
                check("bp_idle", busy, 0);
            end
            comp = cyc[0];
            if (c == 20) res_ready = 1'b1;
            if (c < 22) tick();
        end

        // Continuous mode on ch3, then drop cont mid-scan.
        cont = 1'b1; comp = 1'b1;
        kick(4'b1000);
        for (int c = 1; c <= 23; c++) begin
            if (c == 8 || c == 15 || c == 22) begin
                check("cont_res", {res_valid, res_ch, res_data}, {1'b1, 2'd3, 5'h1F});
                check("cont_done", scan_done, 1);
            end
            if (c == 9) begin
                check("cont_done_pulse", scan_done, 0);
                check("cont_resample", {busy, sample, ch_sel}, {1'b1, 1'b1, 2'd3});
            end
            if (c == 21) check("cont_busy", busy, 1);
            if (c == 22) check("cont_stop_idle", busy, 0);
            if (c == 23) check("cont_valid_drop", res_valid, 0);
            if (c == 16) cont = 1'b0;
            if (c < 23) tick();
        end

        // Reset during CONVERT, then a fresh scan at normal latency.
        comp = 1'b0;
        kick(4'b0100);
        while (cyc < 4) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {ch_sel, sample, dac, res_valid, res_data, res_ch, scan_done}, 0);
        reset = 1'b0;
        kick(4'b0100);
        while (cyc < 7) tick();
        check("post_rst_early", res_valid, 0);
        tick();
        check("post_rst_res", {res_valid, res_ch, res_data}, {1'b1, 2'd2, 5'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
